// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: WIDTH-bit operands summed one bit per clock, LSB first.
// Each bit passes through two half-adder stages with a registered carry between bits.
`timescale 1ns/1ps
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             busy_d, done_d, cout_d;

  // Full-adder slice on the current LSB pair
  logic s1, c1, s, c2, carry_nxt;
  always_comb begin
    s1        = a_sh_q[0] ^ b_sh_q[0];
    c1        = a_sh_q[0] & b_sh_q[0];
    s         = s1 ^ carry_q;
    c2        = s1 & carry_q;
    carry_nxt = c1 | c2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      count_q <= count_d;
      carry_q <= carry_d;
      busy    <= busy_d;
      done    <= done_d;
      sum     <= sum_d;
      cout    <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    count_d = count_q;
    carry_d = carry_q;
    busy_d  = busy;
    done_d  = 1'b0;
    sum_d   = sum;
    cout_d  = cout;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_sh_d  = a;
          b_sh_d  = b;
          count_d = '0;
          carry_d = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ADD: begin
        sum_d   = {s, sum[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = carry_nxt;
        count_d = count_q + CW'(1);
        // Last bit: latch the final carry and leave ADD
        if (count_q == CW'(WIDTH - 1)) begin
          cout_d  = carry_nxt;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected sums queued at start, popped on done.
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ops    = 0;
  int done_cnt = 0;
  logic [W:0] sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Result monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) check("extra_done", 32'd1, 32'd0);
      else check("result", 32'({cout, sum}), 32'(sb.pop_front()));
    end
  end

  // One operation from an IDLE negedge; poke>0 re-pulses start with new operands mid-add
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int poke);
    logic [W:0] exp;
    int lat;
    bit seen;
    exp = (W+1)'(ta) + (W+1)'(tb_v);
    a = ta; b = tb_v; start = 1'b1;
    sb.push_back(exp);
    n_ops++;
    @(negedge clk);
    start = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
    check("done_early", 32'(done), 32'd0);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 4 * W) begin
      if (poke > 0 && lat == poke - 1) begin
        start = 1'b1; a = 8'h11; b = 8'h22;
      end else if (poke > 0 && lat == poke) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (done === 1'b1) seen = 1'b1;
    end
    check("latency", 32'(lat), 32'(W));
    check("busy_off", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("hold", 32'({cout, sum}), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] corners [8];
    int t [3];
    int nd, cyc, dc;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h55, 8'hAA};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(8'h00, 8'h00, 0);
    do_op(8'hA5, 8'h5A, 0);
    do_op(8'hFF, 8'h01, 0);
    do_op(8'h80, 8'h80, 0);

    // Start and operand changes mid-operation are ignored
    do_op(8'h3C, 8'h0F, 2);

    // Corner cross-product and random pairs
    foreach (corners[i]) foreach (corners[j]) do_op(corners[i], corners[j], 0);
    for (int k = 0; k < 1500; k++) do_op(W'($urandom), W'($urandom), 0);

    // Start held high: back-to-back ops, done every W+2 cycles
    a = 8'h01; b = 8'h01; start = 1'b1;
    repeat (3) begin sb.push_back(9'h002); n_ops++; end
    t = '{0, 0, 0};
    nd = 0; cyc = 0;
    while (nd < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        t[nd] = cyc;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_first", 32'(t[0]), 32'(W + 1));
    check("b2b_gap1", 32'(t[1] - t[0]), 32'(W + 2));
    check("b2b_gap2", 32'(t[2] - t[1]), 32'(W + 2));
    @(negedge clk);

    // Reset during the 4th ADD cycle aborts the operation immediately
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    void'(sb.pop_back());
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (20) @(negedge clk);
    check("idle_no_done", 32'(done_cnt), 32'(dc));
    check("idle_busy", 32'(busy), 32'd0);
    do_op(8'hFF, 8'hFF, 0);

    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(n_ops));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
